// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S sine transmitter.
// Frame/slot geometry and the IDLE/RUN state encoding.
package i2s_pkg;
  localparam int I2S_FRAME_BITS = 32;
  localparam int I2S_SLOT_BITS  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV while run is high.
// Ports: clk, rst_n, run in; bclk plus 1-clk rise/fall enables out.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = run && (cnt == LAST);
  assign rise = wrap && !bclk;
  assign fall = wrap && bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_sine_tx.sv
// Philips I2S transmitter streaming a phase-addressed sine table.
// Ports: enable/phase_inc/lut_value in; lut_addr, i2s_* and strobe out.
module i2s_sine_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LUT_DEPTH   = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  output logic [LUT_DEPTH-1:0]   lut_addr,
  input  logic [DATA_WIDTH-1:0]  lut_value,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   sample_strobe
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SIGN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [4:0] LAST_BIT = 5'(I2S_FRAME_BITS - 1);
  localparam logic [4:0] PRE_LAST = 5'(I2S_FRAME_BITS - 2);
  localparam logic [4:0] LR_BIT   = 5'(I2S_SLOT_BITS - 1);

  state_t                 state;
  logic                   tail;
  logic                   en_q;
  logic                   lsb_dly;
  logic [4:0]             bit_cnt;
  logic [PHASE_WIDTH-1:0] phase_acc;
  logic [SW-1:0]          shreg;
  logic [DATA_WIDTH-1:0]  sample;
  logic                   run;
  logic                   bclk_rise;
  logic                   bclk_fall;
  logic                   frame_end;
  logic                   start;
  logic                   trail;
  logic                   stop;
  logic                   shift;

  i2s_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .bclk (i2s_bclk),
    .rise (bclk_rise),
    .fall (bclk_fall)
  );

  assign run       = (state == RUN);
  assign lut_addr  = phase_acc[PHASE_WIDTH-1 -: LUT_DEPTH];
  assign sample    = lut_value ^ SIGN;
  assign frame_end = run && bclk_fall && !tail &&
                     (bit_cnt == LAST_BIT);

  // trail: last frame done, one extra bit carries the right LSB
  assign start = (!run && enable) || (frame_end && en_q);
  assign trail = frame_end && !en_q;
  assign stop  = run && bclk_fall && tail;
  assign shift = run && bclk_fall && !tail &&
                 (bit_cnt != LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tail          <= 1'b0;
      en_q          <= 1'b0;
      lsb_dly       <= 1'b0;
      bit_cnt       <= '0;
      phase_acc     <= '0;
      shreg         <= '0;
      i2s_lrclk     <= 1'b0;
      i2s_sdata     <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= start;
      // enable is looked at half a bit before the frame boundary
      if (bclk_rise) en_q <= enable;
      unique case (1'b1)
        start: begin
          state     <= RUN;
          en_q      <= 1'b1;
          bit_cnt   <= '0;
          phase_acc <= phase_acc + phase_inc;
          shreg     <= {sample, sample};
          i2s_lrclk <= 1'b0;
          i2s_sdata <= lsb_dly;
        end
        trail: begin
          tail      <= 1'b1;
          bit_cnt   <= '0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= lsb_dly;
        end
        stop: begin
          state     <= IDLE;
          tail      <= 1'b0;
          lsb_dly   <= 1'b0;
          shreg     <= '0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= 1'b0;
        end
        shift: begin
          bit_cnt   <= bit_cnt + 5'd1;
          shreg     <= {shreg[SW-2:0], 1'b0};
          i2s_sdata <= shreg[SW-1];
          if (bit_cnt == LR_BIT) i2s_lrclk <= 1'b1;
          // right LSB is held back one bit (Philips delay)
          if (bit_cnt == PRE_LAST) lsb_dly <= shreg[SW-2];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_sine_tx.sv
// Bench for i2s_sine_tx: I2S receiver plus table/phase model.
// Vector table, randomized runs and reset/stop corner sequences.
module tb_i2s_sine_tx;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] phase_inc = '0;
  logic [7:0]  lut_addr;
  logic [15:0] lut_value;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        strobe;

  logic [15:0] lut [256];
  assign lut_value = lut[lut_addr];

  i2s_sine_tx #(
    .CLK_DIV(CD),
    .LUT_DEPTH(8),
    .DATA_WIDTH(16),
    .PHASE_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .phase_inc    (phase_inc),
    .lut_addr     (lut_addr),
    .lut_value    (lut_value),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sdata    (sdata),
    .sample_strobe(strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    logic        chan;
    int          nbits;
  } rx_t;

  rx_t         rx_q[$];
  int          strobes = 0;
  int          rises = 0;
  int          nb = 0;
  logic        lr_prev = 1'b0;
  logic [15:0] sr = '0;
  logic        bclk_q = 1'b0;

  // I2S receiver: a word is complete at the bit where LRCLK flips
  always @(negedge clk) begin
    if (!rst_n) begin
      nb      = 0;
      lr_prev = 1'b0;
      sr      = '0;
      bclk_q  = 1'b0;
    end else begin
      if (strobe) strobes++;
      if (bclk && !bclk_q) begin
        rises++;
        sr = {sr[14:0], sdata};
        nb++;
        if (lrclk != lr_prev) begin
          rx_q.push_back('{word: sr, chan: lr_prev, nbits: nb});
          nb      = 0;
          lr_prev = lrclk;
        end
      end
      bclk_q = bclk;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [15:0] ph;

  function automatic logic [15:0] model_word(input logic [15:0] p);
    logic [7:0] a;
    a = p[15:8];
    return lut[a] ^ 16'h8000;
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ph    = '0;
    @(negedge clk);
  endtask

  task automatic finish_run(input logic [15:0] inc, input int nfr,
                            input int base, input int s0);
    int r;
    repeat (20*CD) @(negedge clk);
    enable = 1'b0;
    repeat (64*CD) @(negedge clk);
    chk("strobes", strobes - s0, nfr);
    chk("idle_bclk", bclk, 0);
    chk("idle_lrclk", lrclk, 0);
    chk("idle_sdata", sdata, 0);
    r = rises;
    repeat (8*CD) @(negedge clk);
    chk("bclk_stopped", rises - r, 0);
    chk("nwords", rx_q.size() - base, 2*nfr);
    for (int i = 0; i < 2*nfr && base + i < rx_q.size(); i++) begin
      rx_t         w;
      logic [15:0] p;
      w = rx_q[base + i];
      p = ph + 16'(inc * (i / 2));
      chk("word", w.word, model_word(p));
      chk("slot", w.chan * 100 + w.nbits,
          (i % 2) * 100 + ((i == 0) ? 17 : 16));
    end
    ph = ph + 16'(inc * nfr);
  endtask

  task automatic run(input logic [15:0] inc, input int nfr,
                     output int base);
    int s0;
    phase_inc = inc;
    base      = rx_q.size();
    s0        = strobes;
    enable    = 1'b1;
    for (int k = 0; k < nfr*64*CD + 64; k++) begin
      @(negedge clk);
      if (strobes >= s0 + nfr) break;
    end
    finish_run(inc, nfr, base, s0);
  endtask

  task automatic wait_bclk(input logic lvl, output int t);
    int k;
    for (k = 0; k < 8*CD; k++) begin
      if (bclk == lvl) break;
      @(negedge clk);
    end
    chk("bclk_wait", bclk, lvl);
    t = cyc;
  endtask

  task automatic wait_strobe(input int lim, output int t);
    int k;
    for (k = 0; k < lim; k++) begin
      @(negedge clk);
      if (strobe) break;
    end
    chk("strobe_seen", strobe, 1);
    t = cyc;
  endtask

  typedef struct {
    logic [15:0] inc;
    int          nfr;
    logic [7:0]  addr;
    int          kf;
    logic [15:0] word;
  } vec_t;

  vec_t vt [5];

  initial begin
    int          base, s0, t0, t1, t2, t3, idx, nfr;
    logic [15:0] inc;
    logic [31:0] act;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] b;
      b = 8'(a);
      lut[a] = {b, b ^ 8'h5A};
    end
    lut[64]  = 16'hFFFF;
    lut[192] = 16'h0000;

    vt[0] = '{16'h0100, 65, 8'h41, 64, 16'h7FFF};
    vt[1] = '{16'hC000,  5, 8'hC0,  1, 16'h8000};
    vt[2] = '{16'h0000,  3, 8'h00,  2, 16'h805A};
    vt[3] = '{16'hFFFF,  3, 8'hFF,  1, 16'h7FA5};
    vt[4] = '{16'h4080,  2, 8'h81,  1, 16'h7FFF};

    // reset held with enable high
    rst_n     = 1'b0;
    enable    = 1'b1;
    phase_inc = 16'h0100;
    repeat (5) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_addr", lut_addr, 0);

    // release and measure clocking
    ph    = '0;
    base  = rx_q.size();
    s0    = strobes;
    rst_n = 1'b1;
    wait_strobe(16*CD, t0);
    @(negedge clk);
    chk("strobe_width", strobe, 0);
    wait_bclk(1'b1, t1);
    chk("first_rise", t1 - t0, CD);
    wait_bclk(1'b0, t2);
    wait_bclk(1'b1, t2);
    chk("bclk_period", t2 - t1, 2*CD);
    wait_strobe(80*CD, t3);
    chk("frame_len", t3 - t0, 64*CD);
    chk("addr_f1", lut_addr, 8'h02);
    finish_run(16'h0100, 2, base, s0);

    // vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      run(vt[v].inc, vt[v].nfr, base);
      chk("vaddr", lut_addr, vt[v].addr);
      idx = base + 2*vt[v].kf;
      act = (idx + 1 < rx_q.size()) ? 32'(rx_q[idx].word) : 32'hFFFF_FFFF;
      chk("vword_l", act, vt[v].word);
      act = (idx + 1 < rx_q.size()) ? 32'(rx_q[idx+1].word) : 32'hFFFF_FFFF;
      chk("vword_r", act, vt[v].word);
    end

    // phase held while idle, then resumes
    repeat (100) @(negedge clk);
    chk("addr_held", lut_addr, ph[15:8]);
    run(16'h4080, 1, base);
    chk("resume_addr", lut_addr, ph[15:8]);

    // asynchronous reset in the right slot (bit 20)
    do_reset();
    phase_inc = 16'h0300;
    s0        = strobes;
    enable    = 1'b1;
    for (int k = 0; k < 200*CD; k++) begin
      @(negedge clk);
      if (strobes >= s0 + 2) break;
    end
    repeat (40*CD + 2) @(negedge clk);
    chk("lr_bit20", lrclk, 1);
    chk("addr_bit20", lut_addr, 8'h06);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bclk", bclk, 0);
    chk("arst_lrclk", lrclk, 0);
    chk("arst_sdata", sdata, 0);
    chk("arst_addr", lut_addr, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ph    = '0;
    run(16'h0300, 2, base);
    chk("post_rst_addr", lut_addr, 8'h06);

    // randomized runs with held phase between them
    for (int n = 0; n < 4; n++) begin
      inc = 16'($urandom);
      nfr = $urandom_range(1, 3);
      run(inc, nfr, base);
      chk("rand_addr", lut_addr, ph[15:8]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
